m_datapath_mdu: RTL and testbench

Parametrised multi-cycle MIPS datapath that adds an iterative multiply unit with HI/LO registers to the multi-cycle core.
- Holds IR, MDR, ALUOut, PC, the register file, the ALU and all operand/writeback/next-PC muxes.
- Driven by the multi-cycle controller; talks to memory through the MIO bus (`Data_in`, `data_out`, `M_addr`, `MIO_ready`).
- MULT/MULTU run in the background over several cycles and report `mdu_busy` so the controller can stall MFHI/MFLO.

---
 rtl/mips_mc_pkg.sv | 71 +++++++
 rtl/mdu_mul_iter.sv | 144 ++++++++++++++
 rtl/m_datapath_mdu.sv | 218 +++++++++++++++++++++
 tb/tb_m_datapath_mdu.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared encodings for the multi-cycle MIPS datapath with the
// iterative multiply/divide-style unit (multiply only).
//   - datapath width
//   - RegDst, MemtoReg, ALUSrcB, PCSource, MduOp and ALU opcode encodings
//   - MDU state type and an absolute-value helper
package mips_mc_pkg;

  localparam int WIDTH = 32;

  // RegDst: register file write address select
  localparam logic [1:0] REGDST_RT   = 2'b00;
  localparam logic [1:0] REGDST_RD   = 2'b01;
  localparam logic [1:0] REGDST_RA   = 2'b10;
  localparam logic [1:0] REGDST_ZERO = 2'b11;

  // MemtoReg: register file write data select (11x falls back to ALUOut)
  localparam logic [2:0] WB_ALUOUT = 3'b000;
  localparam logic [2:0] WB_MDR    = 3'b001;
  localparam logic [2:0] WB_LUI    = 3'b010;
  localparam logic [2:0] WB_PC     = 3'b011;
  localparam logic [2:0] WB_HI     = 3'b100;
  localparam logic [2:0] WB_LO     = 3'b101;

  // ALUSrcB: second ALU operand select
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PCSource: next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_ALUOUT_ALT = 2'b11;

  // MduOp: command carried by the MduStart strobe
  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_MULT  = 2'b01;
  localparam logic [1:0] MDU_MTHI  = 2'b10;
  localparam logic [1:0] MDU_MTLO  = 2'b11;

  // ALU opcodes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // The result write-back happens on the last RUN cycle, so no separate
  // DONE state is needed.
  typedef enum logic [0:0] {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  // Magnitude of a two's-complement word. 0x8000_0000 maps to itself,
  // which read as unsigned is exactly 2^31.
  function automatic logic [WIDTH-1:0] abs32(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v[WIDTH-1]) begin
      r = ~v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/mdu_mul_iter.sv
// mdu_mul_iter: iterative multiplier that owns HI/LO.
//   clk, reset   - clock, synchronous active-high reset
//   start        - one-cycle command strobe (ignored while busy)
//   op           - MULTU / MULT / MTHI / MTLO
//   rs_val       - multiplicand / MTHI-MTLO source
//   rt_val       - multiplier
//   busy         - multiply in progress
//   hi, lo       - HI/LO registers (hold old values while busy)
module mdu_mul_iter
  import mips_mc_pkg::*;
#(
  parameter int RADIX_BITS = 1  // legal: 1, 2, 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] N_ITER = 6'(32 / RADIX_BITS);

  mdu_state_e  state_r;
  mdu_state_e  state_nx_s;
  logic [63:0] mcand_r;
  logic [31:0] mplier_r;
  logic        sign_r;
  logic [5:0]  count_r;
  logic [63:0] acc_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic        is_mul_s;
  logic        last_s;
  logic [63:0] digit_s;
  logic [63:0] partial_s;
  logic [63:0] sum_s;
  logic [63:0] result_s;

  // Next-state decode: only a multiply command leaves IDLE
  always_comb begin
    state_nx_s = state_r;
    is_mul_s   = (op == MDU_MULTU) || (op == MDU_MULT);
    last_s     = (count_r == 6'd1);
    case (state_r)
      MDU_IDLE: begin
        if (start && is_mul_s) begin
          state_nx_s = MDU_RUN;
        end else begin
          state_nx_s = MDU_IDLE;
        end
      end
      MDU_RUN: begin
        if (last_s) begin
          state_nx_s = MDU_IDLE;
        end else begin
          state_nx_s = MDU_RUN;
        end
      end
      default: state_nx_s = MDU_IDLE;
    endcase
  end

  // One radix step: multiplicand times the low multiplier digit, then the
  // optional sign fix-up applied to the final sum
  always_comb begin
    digit_s   = {{(64-RADIX_BITS){1'b0}}, mplier_r[RADIX_BITS-1:0]};
    partial_s = mcand_r * digit_s;
    sum_s     = acc_r + partial_s;
    if (sign_r) begin
      result_s = ~sum_s + 64'd1;
    end else begin
      result_s = sum_s;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= MDU_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Operand latches, accumulator, counter and HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_r  <= 64'd0;
      mplier_r <= 32'd0;
      sign_r   <= 1'b0;
      count_r  <= 6'd0;
      acc_r    <= 64'd0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
    end else begin
      case (state_r)
        MDU_IDLE: begin
          if (start) begin
            case (op)
              MDU_MULTU: begin
                mcand_r  <= {32'd0, rs_val};
                mplier_r <= rt_val;
                sign_r   <= 1'b0;
                count_r  <= N_ITER;
                acc_r    <= 64'd0;
              end
              MDU_MULT: begin
                mcand_r  <= {32'd0, abs32(rs_val)};
                mplier_r <= abs32(rt_val);
                sign_r   <= rs_val[31] ^ rt_val[31];
                count_r  <= N_ITER;
                acc_r    <= 64'd0;
              end
              MDU_MTHI: hi_r <= rs_val;
              MDU_MTLO: lo_r <= rs_val;
              default: ;
            endcase
          end
        end
        MDU_RUN: begin
          acc_r    <= sum_s;
          mcand_r  <= mcand_r << RADIX_BITS;
          mplier_r <= mplier_r >> RADIX_BITS;
          count_r  <= count_r - 6'd1;
          if (last_s) begin
            hi_r <= result_s[63:32];
            lo_r <= result_s[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_r == MDU_RUN);
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: rtl/m_datapath_mdu.sv
// m_datapath_mdu: multi-cycle MIPS datapath with an iterative multiply unit.
//   clk, reset              - clock, synchronous active-high reset
//   MIO_ready               - memory ready, gates PC and IR writes
//   IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA, ALUSrcB,
//   PCSource, PCWrite, PCWriteCond, Branch, ALU_operation
//                           - controller selects/enables
//   MduStart, MduOp         - MDU command strobe and opcode
//   Data_in                 - memory read data
//   PC_Current, Inst        - PC and IR
//   data_out, M_addr        - store data (rt) and memory address
//   zero, overflow          - ALU flags
//   mdu_busy                - multiply in progress
module m_datapath_mdu
  import mips_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MIO_ready,
  input  logic        IorD,
  input  logic        IRWrite,
  input  logic [1:0]  RegDst,
  input  logic        RegWrite,
  input  logic [2:0]  MemtoReg,
  input  logic        ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic [1:0]  PCSource,
  input  logic        PCWrite,
  input  logic        PCWriteCond,
  input  logic        Branch,
  input  logic [2:0]  ALU_operation,
  input  logic        MduStart,
  input  logic [1:0]  MduOp,
  input  logic [31:0] Data_in,
  output logic [31:0] PC_Current,
  output logic [31:0] Inst,
  output logic [31:0] data_out,
  output logic [31:0] M_addr,
  output logic        zero,
  output logic        overflow,
  output logic        mdu_busy
);

  logic [31:0] ir_r;
  logic [31:0] mdr_r;
  logic [31:0] alu_out_r;
  logic [31:0] pc_r;
  logic [31:0] rf_r [0:31];

  logic [4:0]  rs_addr_s;
  logic [4:0]  rt_addr_s;
  logic [4:0]  wr_addr_s;
  logic [31:0] rs_data_s;
  logic [31:0] rt_data_s;
  logic [31:0] wr_data_s;
  logic [31:0] imm_ext_s;
  logic [31:0] alu_a_s;
  logic [31:0] alu_b_s;
  logic [31:0] alu_res_s;
  logic        alu_ovf_s;
  logic [31:0] pc_next_s;
  logic        pc_wen_s;
  logic [31:0] hi_s;
  logic [31:0] lo_s;
  logic        busy_s;

  // Register file read ports; $0 is hard-wired to zero
  always_comb begin
    rs_addr_s = ir_r[25:21];
    rt_addr_s = ir_r[20:16];
    if (rs_addr_s == 5'd0) begin
      rs_data_s = 32'd0;
    end else begin
      rs_data_s = rf_r[rs_addr_s];
    end
    if (rt_addr_s == 5'd0) begin
      rt_data_s = 32'd0;
    end else begin
      rt_data_s = rf_r[rt_addr_s];
    end
    imm_ext_s = {{16{ir_r[15]}}, ir_r[15:0]};
  end

  // Write address (RegDst) and 8-way write-back (MemtoReg) muxes
  always_comb begin
    wr_addr_s = rt_addr_s;
    case (RegDst)
      REGDST_RT:   wr_addr_s = rt_addr_s;
      REGDST_RD:   wr_addr_s = ir_r[15:11];
      REGDST_RA:   wr_addr_s = 5'd31;
      REGDST_ZERO: wr_addr_s = 5'd0;
      default:     wr_addr_s = rt_addr_s;
    endcase
    wr_data_s = alu_out_r;
    case (MemtoReg)
      WB_ALUOUT: wr_data_s = alu_out_r;
      WB_MDR:    wr_data_s = mdr_r;
      WB_LUI:    wr_data_s = {ir_r[15:0], 16'h0000};
      WB_PC:     wr_data_s = pc_r;
      WB_HI:     wr_data_s = hi_s;
      WB_LO:     wr_data_s = lo_s;
      default:   wr_data_s = alu_out_r;
    endcase
  end

  // ALU operand muxes
  always_comb begin
    if (ALUSrcA) begin
      alu_a_s = rs_data_s;
    end else begin
      alu_a_s = pc_r;
    end
    alu_b_s = rt_data_s;
    case (ALUSrcB)
      SRCB_RT:     alu_b_s = rt_data_s;
      SRCB_FOUR:   alu_b_s = 32'd4;
      SRCB_IMM:    alu_b_s = imm_ext_s;
      SRCB_IMM_SH: alu_b_s = {imm_ext_s[29:0], 2'b00};
      default:     alu_b_s = rt_data_s;
    endcase
  end

  // ALU with signed overflow detection on ADD/SUB
  always_comb begin
    alu_res_s = 32'd0;
    alu_ovf_s = 1'b0;
    case (ALU_operation)
      ALU_AND: alu_res_s = alu_a_s & alu_b_s;
      ALU_OR:  alu_res_s = alu_a_s | alu_b_s;
      ALU_ADD: begin
        alu_res_s = alu_a_s + alu_b_s;
        alu_ovf_s = (alu_a_s[31] == alu_b_s[31]) && (alu_res_s[31] != alu_a_s[31]);
      end
      ALU_XOR: alu_res_s = alu_a_s ^ alu_b_s;
      ALU_NOR: alu_res_s = ~(alu_a_s | alu_b_s);
      ALU_SRL: alu_res_s = alu_b_s >> alu_a_s[4:0];
      ALU_SUB: begin
        alu_res_s = alu_a_s - alu_b_s;
        alu_ovf_s = (alu_a_s[31] != alu_b_s[31]) && (alu_res_s[31] != alu_a_s[31]);
      end
      ALU_SLT: alu_res_s = {31'd0, ($signed(alu_a_s) < $signed(alu_b_s))};
      default: alu_res_s = 32'd0;
    endcase
  end

  // Next-PC mux and PC write enable (branch taken when zero matches Branch)
  always_comb begin
    pc_next_s = alu_res_s;
    case (PCSource)
      PCSRC_ALU:        pc_next_s = alu_res_s;
      PCSRC_ALUOUT:     pc_next_s = alu_out_r;
      PCSRC_JUMP:       pc_next_s = {pc_r[31:28], ir_r[25:0], 2'b00};
      PCSRC_ALUOUT_ALT: pc_next_s = alu_out_r;
      default:          pc_next_s = alu_res_s;
    endcase
    pc_wen_s = MIO_ready && (PCWrite || (PCWriteCond && (Branch == zero)));
  end

  // PC register
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else if (pc_wen_s) begin
      pc_r <= pc_next_s;
    end else begin
      pc_r <= pc_r;
    end
  end

  // IR, MDR and ALUOut carry no reset value
  always_ff @(posedge clk) begin
    mdr_r     <= Data_in;
    alu_out_r <= alu_res_s;
    if (IRWrite && MIO_ready) begin
      ir_r <= Data_in;
    end else begin
      ir_r <= ir_r;
    end
  end

  // Register file write port; writes to $0 are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        rf_r[i] <= 32'd0;
      end
    end else if (RegWrite && (wr_addr_s != 5'd0)) begin
      rf_r[wr_addr_s] <= wr_data_s;
    end else begin
      rf_r <= rf_r;
    end
  end

  mdu_mul_iter #(
    .RADIX_BITS(RADIX_BITS)
  ) u_mdu (
    .clk    (clk),
    .reset  (reset),
    .start  (MduStart),
    .op     (MduOp),
    .rs_val (rs_data_s),
    .rt_val (rt_data_s),
    .busy   (busy_s),
    .hi     (hi_s),
    .lo     (lo_s)
  );

  assign PC_Current = pc_r;
  assign Inst       = ir_r;
  assign data_out   = rt_data_s;
  assign M_addr     = IorD ? alu_out_r : pc_r;
  assign zero       = (alu_res_s == 32'd0);
  assign overflow   = alu_ovf_s;
  assign mdu_busy   = busy_s;

endmodule

// File: tb/tb_m_datapath_mdu.sv
// Bench: two datapath instances (RADIX_BITS=1 and 4) share every input.
// HI/LO are observed architecturally by writing them into $3 and reading rt.
module tb_m_datapath_mdu;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset, MIO_ready, IorD, IRWrite, RegWrite, ALUSrcA;
  logic        PCWrite, PCWriteCond, Branch, MduStart;
  logic [1:0]  RegDst, ALUSrcB, PCSource, MduOp;
  logic [2:0]  MemtoReg, ALU_operation;
  logic [31:0] Data_in;

  logic [31:0] pc1, inst1, dout1, addr1, pc4, inst4, dout4, addr4;
  logic        zero1, ovf1, busy1, zero4, ovf4, busy4;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  m_datapath_mdu #(.RESET_PC(RST_PC), .RADIX_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .MIO_ready(MIO_ready), .IorD(IorD), .IRWrite(IRWrite),
    .RegDst(RegDst), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .Branch(Branch), .ALU_operation(ALU_operation), .MduStart(MduStart), .MduOp(MduOp),
    .Data_in(Data_in), .PC_Current(pc1), .Inst(inst1), .data_out(dout1), .M_addr(addr1),
    .zero(zero1), .overflow(ovf1), .mdu_busy(busy1)
  );

  m_datapath_mdu #(.RESET_PC(RST_PC), .RADIX_BITS(4)) dut4 (
    .clk(clk), .reset(reset), .MIO_ready(MIO_ready), .IorD(IorD), .IRWrite(IRWrite),
    .RegDst(RegDst), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .Branch(Branch), .ALU_operation(ALU_operation), .MduStart(MduStart), .MduOp(MduOp),
    .Data_in(Data_in), .PC_Current(pc4), .Inst(inst4), .data_out(dout4), .M_addr(addr4),
    .zero(zero4), .overflow(ovf4), .mdu_busy(busy4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ir(input logic [4:0] rs, input logic [4:0] rt);
    Data_in   = {6'd0, rs, rt, 16'h0000};
    IRWrite   = 1'b1;
    MIO_ready = 1'b1;
    tick();
    IRWrite = 1'b0;
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
    load_ir(5'd0, idx);
    Data_in = val;
    tick();
    RegWrite = 1'b1;
    RegDst   = 2'b00;
    MemtoReg = 3'b001;
    tick();
    RegWrite = 1'b0;
  endtask

  task automatic start_mdu(input logic [1:0] op);
    MduOp    = op;
    MduStart = 1'b1;
    tick();
    MduStart = 1'b0;
  endtask

  // Wait (bounded) until both instances drop busy; expired bound is a failure.
  task automatic wait_done(input int k0, input string tag);
    int e1 = -1;
    int e4 = -1;
    for (int k = k0 + 1; k <= 40; k++) begin
      tick();
      if (e4 < 0 && !busy4) e4 = k;
      if (e1 < 0 && !busy1) e1 = k;
      if (e1 >= 0 && e4 >= 0) break;
    end
    check({tag, "_lat_r1"}, 64'(e1), 64'd32);
    check({tag, "_lat_r4"}, 64'(e4), 64'd8);
  endtask

  task automatic read_hilo(output logic [31:0] h1, output logic [31:0] l1,
                           output logic [31:0] h4, output logic [31:0] l4);
    load_ir(5'd0, 5'd3);
    RegWrite = 1'b1;
    RegDst   = 2'b00;
    MemtoReg = 3'b100;
    tick();
    h1 = dout1;
    h4 = dout4;
    MemtoReg = 3'b101;
    tick();
    l1 = dout1;
    l4 = dout4;
    RegWrite = 1'b0;
  endtask

  task automatic push_exp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    exp_t e;
    if (op == 2'b01) p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
    else             p = {32'd0, a} * {32'd0, b};
    e.hi = p[63:32];
    e.lo = p[31:0];
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] h1, l1, h4, l4;
    exp_t e;
    read_hilo(h1, l1, h4, l4);
    check({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_hi_r1"}, 64'(h1), 64'(e.hi));
      check({tag, "_lo_r1"}, 64'(l1), 64'(e.lo));
      check({tag, "_hi_r4"}, 64'(h4), 64'(e.hi));
      check({tag, "_lo_r4"}, 64'(l4), 64'(e.lo));
    end
  endtask

  task automatic do_mult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
    write_reg(5'd1, a);
    write_reg(5'd2, b);
    load_ir(5'd1, 5'd2);
    push_exp(op, a, b);
    start_mdu(op);
    check({tag, "_busy_r1"}, 64'(busy1), 64'd1);
    check({tag, "_busy_r4"}, 64'(busy4), 64'd1);
    wait_done(0, tag);
    pop_check(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] h1, l1, h4, l4;
    reset = 1'b1; MIO_ready = 1'b1; IorD = 1'b0; IRWrite = 1'b0; RegWrite = 1'b0;
    ALUSrcA = 1'b0; PCWrite = 1'b0; PCWriteCond = 1'b0; Branch = 1'b0; MduStart = 1'b0;
    RegDst = 2'b00; ALUSrcB = 2'b01; PCSource = 2'b00; MduOp = 2'b00;
    MemtoReg = 3'b000; ALU_operation = 3'b010; Data_in = 32'd0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_pc", 64'(pc1), 64'(RST_PC));
    check("rst_busy", 64'({busy1, busy4}), 64'd0);
    load_ir(5'd0, 5'd7);
    check("rst_reg7", 64'(dout1), 64'd0);

    // Multiplies (RADIX 1 and 4 in parallel)
    do_mult(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_ff");
    do_mult(2'b01, 32'hFFFF_FFFD, 32'h0000_0007, "mult_m3x7");

    // -2^31 squared; also ADD overflow/zero on the same operands
    write_reg(5'd1, 32'h8000_0000);
    write_reg(5'd2, 32'h8000_0000);
    load_ir(5'd1, 5'd2);
    ALUSrcA = 1'b1; ALUSrcB = 2'b00; ALU_operation = 3'b010;  // rs + rt
    #1;
    check("add_ovf", 64'({ovf1, ovf4}), 64'd3);
    check("add_zero", 64'(zero1), 64'd1);
    do_mult(2'b01, 32'h8000_0000, 32'h8000_0000, "mult_min_sq");

    // Start while busy: MTHI mid-run ignored, then MTLO afterwards
    write_reg(5'd4, 32'h0000_1234);
    write_reg(5'd5, 32'h0000_0055);
    write_reg(5'd1, 32'h1234_5678);
    write_reg(5'd2, 32'h9ABC_DEF0);
    load_ir(5'd1, 5'd2);
    push_exp(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
    start_mdu(2'b00);
    tick();
    load_ir(5'd4, 5'd0);
    start_mdu(2'b10);
    wait_done(3, "busy_start");
    pop_check("busy_start");
    load_ir(5'd5, 5'd0);
    start_mdu(2'b11);
    read_hilo(h1, l1, h4, l4);
    check("mtlo_lo_r1", 64'(l1), 64'h55);
    check("mtlo_lo_r4", 64'(l4), 64'h55);
    check("mtlo_hi_keep", 64'(h1), 64'(32'h1234_5678 * 64'h9ABC_DEF0 >> 32));

    // Reset mid-multiply
    load_ir(5'd1, 5'd2);
    start_mdu(2'b01);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", 64'({busy1, busy4}), 64'd0);
    check("midrst_pc", 64'({pc1, pc4}), {RST_PC, RST_PC});
    read_hilo(h1, l1, h4, l4);
    check("midrst_hilo_r1", {h1, l1}, 64'd0);
    check("midrst_hilo_r4", {h4, l4}, 64'd0);

    // MIO_ready stall of PC and IR
    load_ir(5'd1, 5'd2);
    ALUSrcA = 1'b0; ALUSrcB = 2'b01; ALU_operation = 3'b010; PCSource = 2'b00;
    PCWrite = 1'b1; IRWrite = 1'b1; MIO_ready = 1'b0; Data_in = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", 64'(pc1), 64'(RST_PC));
      check("stall_ir", 64'(inst1), 64'h0022_0000);
    end
    MIO_ready = 1'b1;
    tick();
    PCWrite = 1'b0; IRWrite = 1'b0;
    check("stall_pc_go", 64'(pc1), 64'(RST_PC + 32'd4));
    check("stall_ir_go", 64'(inst1), 64'hDEAD_BEEF);
    check("maddr_pc", 64'(addr1), 64'(RST_PC + 32'd4));

    // Branch condition using the jump target as next PC
    write_reg(5'd1, 32'd5);
    write_reg(5'd2, 32'd5);
    write_reg(5'd3, 32'd6);
    load_ir(5'd1, 5'd2);
    ALUSrcA = 1'b1; ALUSrcB = 2'b00; ALU_operation = 3'b110; PCSource = 2'b10;
    PCWriteCond = 1'b1; Branch = 1'b1;
    #1;
    check("br_zero1", 64'(zero1), 64'd1);
    tick();
    check("br_taken_z1", 64'(pc1), 64'h0088_0000);
    Branch = 1'b0;
    tick();
    check("br_nt_z1", 64'(pc1), 64'h0088_0000);
    PCWriteCond = 1'b0;
    load_ir(5'd1, 5'd3);
    PCWriteCond = 1'b1;
    #1;
    check("br_zero0", 64'(zero1), 64'd0);
    tick();
    check("br_taken_z0", 64'(pc1), 64'h008C_0000);
    Branch = 1'b1;
    PCWriteCond = 1'b1;
    load_ir(5'd1, 5'd3);
    check("br_nt_z0", 64'({pc1, pc4}), {32'h008C_0000, 32'h008C_0000});
    PCWriteCond = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
